// File: rtl/div_if.sv
// rtl/div_if.sv - operand/result handshake bundle for the div block
// Ports (slave = divider side):
//   a_in, b_in, valid_f_in -> ready_f_in        upstream operand handshake
//   quotient, remainder, valid_f_out <- ready_f_out  downstream result handshake
//   div_zero                                     only with DIV_ZERO_DETECT_EN
interface div_if #(
  parameter int DATA_SIZE = 16
);
  logic [DATA_SIZE-1:0] a_in;
  logic [DATA_SIZE-1:0] b_in;
  logic                 valid_f_in;
  logic                 ready_f_in;
  logic                 valid_f_out;
  logic                 ready_f_out;
  logic [DATA_SIZE-1:0] quotient;
  logic [DATA_SIZE-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic                 div_zero;
`endif

  modport slave (
    input  a_in, b_in, valid_f_in, ready_f_out,
    output ready_f_in, valid_f_out, quotient, remainder
`ifdef DIV_ZERO_DETECT_EN
    , output div_zero
`endif
  );

  modport master (
    output a_in, b_in, valid_f_in, ready_f_out,
    input  ready_f_in, valid_f_out, quotient, remainder
`ifdef DIV_ZERO_DETECT_EN
    , input div_zero
`endif
  );
endinterface

// File: rtl/div.sv
// rtl/div.sv - sequential restoring shift-subtract unsigned divider, one quotient bit per cycle
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    div_if.slave: operands in (a_in/b_in/valid_f_in/ready_f_in),
//          results out (quotient/remainder/valid_f_out/ready_f_out[/div_zero])
// Optional macro DIV_ZERO_DETECT_EN: zero divisor finishes in one cycle and flags div_zero.
module div #(
  parameter int DATA_SIZE = 16
) (
  input  logic clk,
  input  logic rst_n,
  div_if.slave bus
);

  localparam int CW = $clog2(DATA_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] rem_q, rem_d;
  logic [DATA_SIZE-1:0] quo_q, quo_d;
  logic [DATA_SIZE-1:0] dvs_q, dvs_d;
  logic [DATA_SIZE:0]   rem_shift;
  logic [DATA_SIZE:0]   trial;
`ifdef DIV_ZERO_DETECT_EN
  logic                 dz_q, dz_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while the new quotient bit enters at the LSB.
    // The extra top bit of the trial difference is its sign.
    rem_shift = {rem_q, quo_q[DATA_SIZE-1]};
    trial     = rem_shift - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (bus.valid_f_in) begin
          dvs_d   = bus.b_in;
          quo_d   = bus.a_in;
          rem_d   = '0;
          cnt_d   = CW'(DATA_SIZE);
          state_d = BUSY;
`ifdef DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
          if (bus.b_in == '0) begin
            quo_d   = '1;
            rem_d   = bus.a_in;
            cnt_d   = '0;
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        if (!trial[DATA_SIZE]) begin
          rem_d = trial[DATA_SIZE-1:0];
          quo_d = {quo_q[DATA_SIZE-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DATA_SIZE-1:0];
          quo_d = {quo_q[DATA_SIZE-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready_f_out) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready_f_in  = (state_q == IDLE);
  assign bus.valid_f_out = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_zero    = dz_q;
`endif

endmodule
